// File: rtl/spi_reg_writer.sv
// spi_reg_writer: SPI mode-0 master sending 16-bit {addr,5'b0,data} register-write frames.
// Define SPI_WR_FIFO_EN to put a FIFO_DEPTH-entry command FIFO in front of the frame FSM.
module spi_reg_writer #(
  parameter int CLK_DIV    = 4,
  parameter int CS_HOLD    = 2,
  parameter int CS_IDLE    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       spi_clk,
  output logic       spi_cs_n,
  output logic       spi_mosi
);
  localparam int CMAX = (CLK_DIV > CS_HOLD) ? ((CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE)
                                            : ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
  localparam int CW = $clog2(CMAX);
  typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic done_q, done_d, busy_q, busy_d, ready_q, ready_d;
  logic cmd_valid, start, last;
  logic [10:0] cmd;
  int tc;
`ifdef SPI_WR_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [10:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] count_q, count_d;
  logic push;
  assign push      = wr_valid && ready_q;
  assign cmd_valid = count_q != '0;
  assign cmd       = mem[rp_q];
  assign count_d   = count_q + (AW+1)'(push) - (AW+1)'(start);
  assign ready_d   = count_d != (AW+1)'(FIFO_DEPTH);
  assign busy_d    = (state_d != IDLE) || (count_d != '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        mem[wp_q] <= {wr_addr, wr_data};
        wp_q      <= wp_q + AW'(1);
      end
      if (start) rp_q <= rp_q + AW'(1);
    end
  end
`else
  logic unused_depth;
  assign unused_depth = FIFO_DEPTH > 0;
  assign cmd_valid    = wr_valid && ready_q;
  assign cmd          = {wr_addr, wr_data};
  assign ready_d      = state_d == IDLE;
  assign busy_d       = state_d != IDLE;
`endif
  // A queued command may start straight from the last GAP cycle so frames stay CS_IDLE apart.
  always_comb begin
    tc      = (state_q == HOLD) ? CS_HOLD : (state_q == GAP) ? CS_IDLE : CLK_DIV;
    last    = cnt_q == CW'(tc - 1);
    start   = cmd_valid && (state_q == IDLE || (state_q == GAP && last));
    state_d = state_q;
    cnt_d   = (state_q == IDLE || last) ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      LOW:  state_d = last ? HIGH : LOW;
      HIGH: if (last) begin
        if (bit_q == 4'd15) state_d = HOLD;
        else begin
          state_d = LOW;
          shift_d = {shift_q[14:0], 1'b0};
          bit_d   = bit_q + 4'd1;
        end
      end
      HOLD: state_d = last ? GAP : HOLD;
      GAP:  state_d = last ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = LOW;
      shift_d = {cmd[10:8], 5'b0, cmd[7:0]};
      bit_d   = '0;
      cnt_d   = '0;
    end
    cs_n_d = !(state_d == LOW || state_d == HIGH || state_d == HOLD);
    sclk_d = state_d == HIGH;
    mosi_d = (state_d == LOW || state_d == HIGH) && shift_d[15];
    done_d = state_d == GAP && state_q != GAP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end
  assign wr_ready = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_clk  = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;
endmodule
